// File: rtl/huff_pkg.sv
// -----------------------------------------------------------------------------
// huff_pkg
// Shared types and constants for the bit-serial Huffman tree decoder.
//   - huff_entry_t : table entry {valid, leaf, payload} at the default width
//   - ENT_VALID / ENT_LEAF : bit offsets of the flag fields above the payload,
//     so an entry vector of any PAY_W is entry[PAY_W+ENT_VALID] / [PAY_W+ENT_LEAF]
//   - walk_state_t : walk FSM encoding, also exported on the debug port
//   - *_DEF : default parameter values
// -----------------------------------------------------------------------------
package huff_pkg;

    localparam int PAY_W_DEF   = 8;
    localparam int NODE_AW_DEF = 4;
    localparam int MAX_LEN_DEF = 12;
    localparam int LEN_W_DEF   = 4;

    // Flag positions relative to the top of the payload field.
    localparam int ENT_VALID = 1;
    localparam int ENT_LEAF  = 0;

    typedef struct packed {
        logic                 valid;
        logic                 leaf;
        logic [PAY_W_DEF-1:0] payload;
    } huff_entry_t;

    // ST_IDLE: at the root with no bits consumed; ST_WALK: partial codeword held.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } walk_state_t;

endpackage

// File: rtl/huffman_tree_decoder_if.sv
// -----------------------------------------------------------------------------
// huffman_tree_decoder_if
// Bit stream in / symbol stream out of the Huffman decoder.
//   bit_valid, bit_in, bit_ready : serial code bits (source -> decoder)
//   sym_valid, sym, sym_len, sym_ready : decoded symbols (decoder -> consumer)
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both high. A producer holding valid keeps its data stable until that edge;
// ready may depend combinationally on the consumer's own state.
// Modports: slave = decoder side, master = source/consumer side.
// -----------------------------------------------------------------------------
interface huffman_tree_decoder_if #(
    parameter int PAY_W = 8,
    parameter int LEN_W = 4
);
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             sym_valid;
    logic             sym_ready;
    logic [PAY_W-1:0] sym;
    logic [LEN_W-1:0] sym_len;

    modport slave (
        input  bit_valid, bit_in, sym_ready,
        output bit_ready, sym_valid, sym, sym_len
    );

    modport master (
        output bit_valid, bit_in, sym_ready,
        input  bit_ready, sym_valid, sym, sym_len
    );
endinterface

// File: rtl/huff_tree_table.sv
// -----------------------------------------------------------------------------
// huff_tree_table
// Code-tree storage: NODES nodes x 2 branches of {valid, leaf, payload}, in flops.
//   clk, reset  : clock, synchronous active-high reset (clears valid bits only)
//   i_we        : write strobe; entry lands at the clock edge
//   i_waddr     : node index to write
//   i_wbranch   : branch (0 = left, 1 = right) to write
//   i_wentry    : entry {valid, leaf, payload}
//   i_rnode     : node index to read
//   i_rbranch   : branch to read
//   o_rentry    : combinational read data (old data during a same-cycle write)
// -----------------------------------------------------------------------------
module huff_tree_table
    import huff_pkg::*;
#(
    parameter int PAY_W   = PAY_W_DEF,
    parameter int NODE_AW = NODE_AW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_we,
    input  logic [NODE_AW-1:0] i_waddr,
    input  logic               i_wbranch,
    input  logic [PAY_W+1:0]   i_wentry,
    input  logic [NODE_AW-1:0] i_rnode,
    input  logic               i_rbranch,
    output logic [PAY_W+1:0]   o_rentry
);

    localparam int SLOTS = 2 * (2 ** NODE_AW);

    // Slot index is {node, branch}.
    logic [PAY_W+1:0] r_mem [SLOTS];

    wire [NODE_AW:0] w_waddr = {i_waddr, i_wbranch};
    wire [NODE_AW:0] w_raddr = {i_rnode, i_rbranch};

    // Only the valid flags are reset; leaf/payload of an invalid slot are
    // never observed, so they need no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_mem[i][PAY_W+ENT_VALID] <= 1'b0;
            end
        end else if (i_we) begin
            r_mem[w_waddr] <= i_wentry;
        end
    end

    assign o_rentry = r_mem[w_raddr];

endmodule

// File: rtl/huffman_tree_decoder.sv
// -----------------------------------------------------------------------------
// huffman_tree_decoder
// Bit-serial Huffman decoder walking a run-time programmable binary code tree.
// One code bit is consumed per accepted cycle; one symbol with its code length
// is emitted per complete codeword.
//   clk, reset  : clock, synchronous active-high reset
//   hif (slave) : bit stream in (bit_valid/bit_in/bit_ready) and symbol stream
//                 out (sym_valid/sym/sym_len/sym_ready)
//   flush       : abandon the partial codeword; the bit presented is dropped
//   cfg_we, cfg_addr, cfg_branch, cfg_entry : tree table write port
//   idle        : no partial codeword in progress
//   err         : sticky decode-error flag, cleared by err_clr
//   err_clr     : clears err (a simultaneous new error wins)
//   err_cnt     : saturating decode-error count, cleared only by reset
//   dbg_state   : walk FSM state
// -----------------------------------------------------------------------------
module huffman_tree_decoder
    import huff_pkg::*;
#(
    parameter int PAY_W   = PAY_W_DEF,
    parameter int NODE_AW = NODE_AW_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    huffman_tree_decoder_if.slave hif,
    input  logic                 flush,
    input  logic                 cfg_we,
    input  logic [NODE_AW-1:0]   cfg_addr,
    input  logic                 cfg_branch,
    input  logic [PAY_W+1:0]     cfg_entry,
    output logic                 idle,
    output logic                 err,
    input  logic                 err_clr,
    output logic [7:0]           err_cnt,
    output walk_state_t          dbg_state
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    walk_state_t        r_state;
    logic [NODE_AW-1:0] r_cur_node;
    logic [LEN_W-1:0]   r_depth;
    logic               r_sym_valid;
    logic [PAY_W-1:0]   r_sym;
    logic [LEN_W-1:0]   r_sym_len;
    logic               r_err;
    logic [7:0]         r_err_cnt;

    walk_state_t        w_state_nxt;
    logic [NODE_AW-1:0] w_node_nxt;
    logic [LEN_W-1:0]   w_depth_nxt;
    logic [PAY_W+1:0]   w_entry;

    // ---------------- tree table ----------------
    huff_tree_table #(
        .PAY_W   (PAY_W),
        .NODE_AW (NODE_AW)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .i_we      (cfg_we),
        .i_waddr   (cfg_addr),
        .i_wbranch (cfg_branch),
        .i_wentry  (cfg_entry),
        .i_rnode   (r_cur_node),
        .i_rbranch (hif.bit_in),
        .o_rentry  (w_entry)
    );

    wire              w_ent_valid = w_entry[PAY_W+ENT_VALID];
    wire              w_ent_leaf  = w_entry[PAY_W+ENT_LEAF];
    wire [PAY_W-1:0]  w_ent_pay   = w_entry[PAY_W-1:0];

    // The output register can be refilled in the same cycle it drains.
    wire w_bit_ready = ~r_sym_valid | hif.sym_ready;
    wire w_accept    = hif.bit_valid & w_bit_ready & ~flush;

    // depth < MAX_LEN < 2**LEN_W always holds, so this never wraps.
    wire [LEN_W-1:0] w_depth_inc = r_depth + LEN_W'(1);

    wire w_hit_leaf   = w_accept & w_ent_valid & w_ent_leaf;
    wire w_hit_branch = w_accept & w_ent_valid & ~w_ent_leaf & (w_depth_inc < MAX_LEN_L);
    // Invalid entry, or an internal branch that would exceed MAX_LEN bits.
    wire w_hit_err    = w_accept & ~w_hit_leaf & ~w_hit_branch;

    // ---------------- walk FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cur_node <= '0;
            r_depth    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_node <= w_node_nxt;
            r_depth    <= w_depth_nxt;
        end
    end

    // ---------------- walk FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_node_nxt  = r_cur_node;
        w_depth_nxt = r_depth;
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_node_nxt  = '0;
            w_depth_nxt = '0;
        end else if (w_hit_branch) begin
            w_state_nxt = ST_WALK;
            w_node_nxt  = w_ent_pay[NODE_AW-1:0];
            w_depth_nxt = w_depth_inc;
        end else if (w_hit_leaf || w_hit_err) begin
            w_state_nxt = ST_IDLE;
            w_node_nxt  = '0;
            w_depth_nxt = '0;
        end
    end

    // ---------------- symbol output register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sym_valid <= 1'b0;
            r_sym       <= '0;
            r_sym_len   <= '0;
        end else if (w_hit_leaf) begin
            r_sym_valid <= 1'b1;
            r_sym       <= w_ent_pay;
            r_sym_len   <= w_depth_inc;
        end else if (hif.sym_ready) begin
            r_sym_valid <= 1'b0;
        end
    end

    // ---------------- error flag and counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_hit_err) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (w_hit_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign hif.bit_ready = w_bit_ready;
    assign hif.sym_valid = r_sym_valid;
    assign hif.sym       = r_sym;
    assign hif.sym_len   = r_sym_len;
    assign idle          = (r_depth == '0);
    assign err           = r_err;
    assign err_cnt       = r_err_cnt;
    assign dbg_state     = r_state;

endmodule
